ws2812b_frame_scheduler: RTL and testbench

- Owns the LED pixel store for one WS2812B chain and sequences the existing WS2812B driver (1-cycle `update_frame` trigger, `program_led_number` index, 8-bit R/G/B inputs).
- Two write requesters share a back buffer through a round-robin arbiter.
- A commit copies back to front, then triggers one frame. The front buffer stays frozen while the driver streams, so frames never tear.
- An optional auto-refresh re-sends the front buffer periodically.

---
 rtl/ws2812b_pkg.sv | 20 ++
 rtl/ws2812b_rr_arbiter2.sv | 25 ++
 rtl/ws2812b_frame_scheduler.sv | 159 +++++++++++++++
 tb/tb_ws2812b_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: driver timing, pixel word layout and scheduler states.
package ws2812b_pkg;

  localparam int BIT_CYCLES   = 63;
  localparam int LATCH_CYCLES = 2601;
  localparam int T0H_CYCLES   = 20;
  localparam int T1H_CYCLES   = 40;

  localparam int RED_LSB   = 16;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    TRIGGER,
    SENDING
  } state_t;

endpackage

// File: rtl/ws2812b_rr_arbiter2.sv
// Two-way round-robin grant; the pointer only moves on contested grants.
module ws2812b_rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr;

  assign gnt0 = !stall && req0 && (!req1 || !ptr);
  assign gnt1 = !stall && req1 && (!req0 || ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (!stall && req0 && req1) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// Double-buffered pixel store and frame sequencer for one WS2812B chain.
// state   | meaning
// IDLE    | waiting for commit or auto-refresh expiry
// COPY    | back[k] -> front[k], one index per cycle
// TRIGGER | one-cycle update_frame pulse to the driver
// SENDING | front frozen while the driver streams and latches
module ws2812b_frame_scheduler
  import ws2812b_pkg::*;
#(
  parameter int MAX_POS             = 16,
  parameter int BIT_CYCLES          = ws2812b_pkg::BIT_CYCLES,
  parameter int LATCH_CYCLES        = ws2812b_pkg::LATCH_CYCLES,
  parameter int GUARD_CYCLES        = 8,
  parameter int AUTO_REFRESH_CYCLES = 0,
  localparam int AW = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr0_valid,
  output logic          wr0_ready,
  input  logic [AW-1:0] wr0_addr,
  input  logic [23:0]   wr0_rgb,
  input  logic          wr1_valid,
  output logic          wr1_ready,
  input  logic [AW-1:0] wr1_addr,
  input  logic [23:0]   wr1_rgb,
  input  logic          commit,
  output logic          busy,
  output logic [15:0]   frame_count,
  output logic          update_frame,
  input  logic [AW-1:0] drv_led_number,
  output logic [7:0]    drv_red,
  output logic [7:0]    drv_green,
  output logic [7:0]    drv_blue
);

  localparam int FRAME_CYCLES = MAX_POS * 24 * BIT_CYCLES + LATCH_CYCLES + GUARD_CYCLES;
  localparam int FW = $clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] FRAME_LOAD = FW'(FRAME_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(MAX_POS - 1);
  localparam int REFRESH_MAX = (AUTO_REFRESH_CYCLES > 0) ? AUTO_REFRESH_CYCLES - 1 : 0;
  localparam int RW = (REFRESH_MAX > 0) ? $clog2(REFRESH_MAX + 1) : 1;
  localparam logic [RW-1:0] REFRESH_TC = RW'(REFRESH_MAX);

  state_t        state;
  logic [AW-1:0] copy_idx;
  logic [FW-1:0] frame_timer;
  logic [RW-1:0] refresh_timer;
  logic          refresh_armed;
  logic          commit_pending;
  logic          refresh_hit;
  logic          copy_stall;

  logic [23:0] back_mem  [MAX_POS];
  logic [23:0] front_mem [MAX_POS];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [23:0]   front_word;

  assign copy_stall = (state == COPY);

  ws2812b_rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .stall (copy_stall),
    .req0  (wr0_valid),
    .req1  (wr1_valid),
    .gnt0  (wr0_ready),
    .gnt1  (wr1_ready)
  );

  assign wr_en   = (wr0_valid && wr0_ready) || (wr1_valid && wr1_ready);
  assign wr_addr = (wr0_valid && wr0_ready) ? wr0_addr : wr1_addr;
  assign wr_data = (wr0_valid && wr0_ready) ? wr0_rgb : wr1_rgb;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      back_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == COPY) begin
      front_mem[copy_idx] <= back_mem[copy_idx];
    end
  end

  assign front_word = front_mem[drv_led_number];
  assign drv_red    = front_word[RED_LSB +: 8];
  assign drv_green  = front_word[GREEN_LSB +: 8];
  assign drv_blue   = front_word[BLUE_LSB +: 8];

  // Auto-refresh stays disarmed after reset until the front buffer has been filled once.
  assign refresh_hit = (AUTO_REFRESH_CYCLES != 0) && refresh_armed && (refresh_timer == REFRESH_TC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      update_frame   <= 1'b0;
      busy           <= 1'b0;
      frame_count    <= 16'd0;
      commit_pending <= 1'b0;
      refresh_timer  <= '0;
      refresh_armed  <= 1'b0;
      copy_idx       <= '0;
      frame_timer    <= '0;
    end else begin
      update_frame <= 1'b0;
      if (commit) begin
        commit_pending <= 1'b1;
      end
      if (refresh_timer != REFRESH_TC) begin
        refresh_timer <= refresh_timer + 1'b1;
      end
      case (state)
        IDLE: begin
          if (commit_pending || commit) begin
            state          <= COPY;
            busy           <= 1'b1;
            copy_idx       <= '0;
            commit_pending <= 1'b0;
            refresh_armed  <= 1'b1;
          end else if (refresh_hit) begin
            state         <= TRIGGER;
            busy          <= 1'b1;
            update_frame  <= 1'b1;
            frame_count   <= frame_count + 16'd1;
            refresh_timer <= '0;
          end
        end
        COPY: begin
          copy_idx <= copy_idx + 1'b1;
          if (copy_idx == LAST_IDX) begin
            state         <= TRIGGER;
            update_frame  <= 1'b1;
            frame_count   <= frame_count + 16'd1;
            refresh_timer <= '0;
          end
        end
        TRIGGER: begin
          state       <= SENDING;
          frame_timer <= FRAME_LOAD;
        end
        SENDING: begin
          if (frame_timer == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            frame_timer <= frame_timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Directed bench for ws2812b_frame_scheduler with a 4-LED chain and 10000-cycle auto-refresh.
module tb_ws2812b_frame_scheduler;

  localparam int MAX_POS = 4;
  localparam int ARC     = 10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [1:0]  wr0_addr, wr1_addr, drv_led_number;
  logic [23:0] wr0_rgb, wr1_rgb;
  logic        commit, busy, update_frame;
  logic [15:0] frame_count;
  logic [7:0]  drv_red, drv_green, drv_blue;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  ws2812b_frame_scheduler #(
    .MAX_POS             (MAX_POS),
    .BIT_CYCLES          (63),
    .LATCH_CYCLES        (2601),
    .GUARD_CYCLES        (8),
    .AUTO_REFRESH_CYCLES (ARC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr0_valid      (wr0_valid),
    .wr0_ready      (wr0_ready),
    .wr0_addr       (wr0_addr),
    .wr0_rgb        (wr0_rgb),
    .wr1_valid      (wr1_valid),
    .wr1_ready      (wr1_ready),
    .wr1_addr       (wr1_addr),
    .wr1_rgb        (wr1_rgb),
    .commit         (commit),
    .busy           (busy),
    .frame_count    (frame_count),
    .update_frame   (update_frame),
    .drv_led_number (drv_led_number),
    .drv_red        (drv_red),
    .drv_green      (drv_green),
    .drv_blue       (drv_blue)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_led(input int idx, input logic [23:0] exp, input string tag);
    drv_led_number = idx[1:0];
    #1;
    check(tag, {8'h00, drv_red, drv_green, drv_blue}, {8'h00, exp});
  endtask

  task automatic wait_update(input int bound, input string tag, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (update_frame) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_timeout"}, {31'd0, update_frame}, 32'd1);
  endtask

  task automatic wait_idle(input int bound, input string tag, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  logic [23:0] pix  [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456};
  logic [23:0] rgb0 [4] = '{24'h100000, 24'h200000, 24'h300000, 24'h400000};
  logic [23:0] rgb1 [4] = '{24'h000010, 24'h000020, 24'h000030, 24'h000040};
  logic        exp_g0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int t_commit, at, t2, t3, seen;
    logic prev_busy;
    reset = 1'b1; commit = 1'b0; drv_led_number = 2'd0;
    wr0_valid = 1'b0; wr0_addr = 2'd0; wr0_rgb = 24'h0;
    wr1_valid = 1'b0; wr1_addr = 2'd0; wr1_rgb = 24'h0;
    repeat (3) tick();
    check("rst_update_frame", {31'd0, update_frame}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    reset = 1'b0;

    // Fill the back buffer through requester 0, then commit.
    for (int i = 0; i < 4; i++) begin
      wr0_valid = 1'b1; wr0_addr = i[1:0]; wr0_rgb = pix[i];
      #1;
      check("wr0_ready_single", {31'd0, wr0_ready}, 32'd1);
      tick();
    end
    wr0_valid = 1'b0;
    commit = 1'b1;
    tick();
    t_commit = cyc;
    commit = 1'b0;
    check("copy_busy", {31'd0, busy}, 32'd1);
    at = -1;
    for (int i = 0; i < 10; i++) begin
      if (update_frame) begin
        at = cyc;
        break;
      end
      wr0_valid = 1'b1; wr1_valid = 1'b1;
      #1;
      check("copy_ready0", {31'd0, wr0_ready}, 32'd0);
      check("copy_ready1", {31'd0, wr1_ready}, 32'd0);
      wr0_valid = 1'b0; wr1_valid = 1'b0;
      tick();
    end
    check("f1_trigger_latency", at - t_commit, 32'd4);
    check("f1_frame_count", {16'd0, frame_count}, 32'd1);
    tick();
    check("f1_single_pulse", {31'd0, update_frame}, 32'd0);
    for (int i = 0; i < 4; i++) read_led(i, pix[i], "f1_drv_rgb");

    // Mid-frame write and double commit; the front buffer must not move.
    repeat (20) tick();
    wr1_valid = 1'b1; wr1_addr = 2'd2; wr1_rgb = 24'hAAAAAA;
    #1;
    check("send_wr1_ready", {31'd0, wr1_ready}, 32'd1);
    tick();
    wr1_valid = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0; tick();
    commit = 1'b1; tick(); commit = 1'b0;
    read_led(2, 24'h0000FF, "frozen_idx2");
    wait_idle(9000, "f1_idle", at);
    check("f1_busy_duration", at - t_commit, 32'd8662);
    wait_update(20, "f2_update", at);
    check("f2_pending_latency", at - t_commit, 32'd8667);
    t2 = at;
    check("f2_frame_count", {16'd0, frame_count}, 32'd2);
    tick();
    read_led(2, 24'hAAAAAA, "f2_idx2");
    read_led(0, 24'hFF0000, "f2_idx0");
    read_led(3, 24'h123456, "f2_idx3");
    wait_idle(9000, "f2_idle", at);
    check("f2_send_length", at - t2, 32'd8658);

    // Contested arbitration in IDLE alternates starting with requester 0.
    for (int k = 0; k < 4; k++) begin
      wr0_valid = 1'b1; wr0_addr = 2'd0; wr0_rgb = rgb0[k];
      wr1_valid = 1'b1; wr1_addr = 2'd1; wr1_rgb = rgb1[k];
      #1;
      check("rr_gnt0", {31'd0, wr0_ready}, {31'd0, exp_g0[k]});
      check("rr_gnt1", {31'd0, wr1_ready}, {31'd0, !exp_g0[k]});
      tick();
    end
    wr0_valid = 1'b0;
    #1;
    check("solo_gnt1", {31'd0, wr1_ready}, 32'd1);
    check("solo_gnt0", {31'd0, wr0_ready}, 32'd0);
    wr1_valid = 1'b0;

    // Auto-refresh resends the front buffer without a copy.
    at = -1;
    prev_busy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      prev_busy = busy;
      tick();
      if (update_frame) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("refresh_timeout", {31'd0, update_frame}, 32'd1);
    check("refresh_period", at - t2, ARC);
    check("refresh_no_copy", {31'd0, prev_busy}, 32'd0);
    check("refresh_frame_count", {16'd0, frame_count}, 32'd3);
    t3 = at;
    read_led(0, 24'hFF0000, "refresh_idx0");
    read_led(2, 24'hAAAAAA, "refresh_idx2");

    // Commit in the same IDLE cycle as refresh expiry takes the copy path.
    while (cyc < t3 + ARC - 1) tick();
    check("prio_idle", {31'd0, busy}, 32'd0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("prio_no_refresh", {31'd0, update_frame}, 32'd0);
    check("prio_copy_busy", {31'd0, busy}, 32'd1);
    wait_update(20, "prio_update", at);
    check("prio_latency", at - t3, ARC + 4);
    check("prio_frame_count", {16'd0, frame_count}, 32'd4);
    tick();
    check("prio_single_pulse", {31'd0, update_frame}, 32'd0);
    read_led(0, 24'h300000, "prio_idx0");
    read_led(1, 24'h000040, "prio_idx1");

    // Reset while sending.
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_update", {31'd0, update_frame}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_frame_count", {16'd0, frame_count}, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < ARC + 100; i++) begin
      tick();
      if (update_frame) seen++;
    end
    check("rst_no_trigger", seen, 32'd0);
    commit = 1'b1;
    tick();
    t_commit = cyc;
    commit = 1'b0;
    wait_update(20, "post_rst_update", at);
    check("post_rst_latency", at - t_commit, 32'd4);
    check("post_rst_frame_count", {16'd0, frame_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
